// File: rtl/hms_alarm_core.sv
`default_nettype none
// ============================================================================
// Module   : hms_alarm_core
// Purpose  : Hours/minutes/seconds clock with settable time, one alarm and an
//            optional snooze. A prescaler divides clk down to a one-second
//            tick that acts as a synchronous clock enable for the time
//            counters; no derived clocks are used.
// Ports    : clk          - single clock, rising edge
//            rst_n        - synchronous reset, ACTIVE HIGH despite the name
//            i_mode_btn   - pulse, CLOCK -> SETUP -> ALARM -> CLOCK
//            i_pos_btn    - pulse, SEC -> MIN -> HOUR (SETUP/ALARM only)
//            i_inc_btn    - pulse, increment selected field
//            i_alarm_tgl  - pulse, toggle o_alarm_en
//            o_hour/o_min/o_sec - displayed time (alarm time in ALARM mode)
//            o_mode, o_position - current mode and edit position
//            o_alarm_en, o_alarm, o_tick - armed, sounding, 1 s tick
// Options  : define HMS_SNOOZE_EN to build the snooze re-trigger logic.
// Revision : 1.0 - initial release
// ============================================================================
module hms_alarm_core #(
  parameter int TICK_DIV   = 50000000,
  parameter int HOUR_MAX   = 23,
  parameter int ALARM_LEN  = 30,
  parameter int SNOOZE_MIN = 5
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_mode_btn,
  input  logic       i_pos_btn,
  input  logic       i_inc_btn,
  input  logic       i_alarm_tgl,
  output logic [4:0] o_hour,
  output logic [5:0] o_min,
  output logic [5:0] o_sec,
  output logic [1:0] o_mode,
  output logic [1:0] o_position,
  output logic       o_alarm_en,
  output logic       o_alarm,
  output logic       o_tick
);

  localparam int c_PRESC_W = $clog2(TICK_DIV);

  if (TICK_DIV < 2) begin : g_chk_tick_div
    $error("TICK_DIV must be 2 or greater");
  end
  if (HOUR_MAX != 11 && HOUR_MAX != 23) begin : g_chk_hour_max
    $error("HOUR_MAX must be 11 or 23");
  end
  if (ALARM_LEN < 1 || ALARM_LEN > 63) begin : g_chk_alarm_len
    $error("ALARM_LEN must be 1..63");
  end
  if (SNOOZE_MIN < 1 || SNOOZE_MIN > 59) begin : g_chk_snooze_min
    $error("SNOOZE_MIN must be 1..59");
  end

  typedef enum logic [1:0] {
    MODE_CLOCK = 2'b00,
    MODE_SETUP = 2'b01,
    MODE_ALARM = 2'b10
  } mode_t;

  typedef enum logic [1:0] {
    POS_SEC  = 2'b00,
    POS_MIN  = 2'b01,
    POS_HOUR = 2'b10
  } pos_t;

  function automatic logic [5:0] wrap_inc(input logic [5:0] v, input logic [5:0] top);
    return (v >= top) ? 6'd0 : v + 6'd1;
  endfunction

  mode_t                r_mode, w_mode_nxt;
  pos_t                 r_pos, w_pos_nxt;
  logic [c_PRESC_W-1:0] r_presc;
  logic [4:0]           r_hour, w_hour_nxt, w_hour_inc;
  logic [5:0]           r_min, w_min_nxt;
  logic [5:0]           r_sec, w_sec_nxt;
  logic [4:0]           r_al_hour, w_al_hour_inc;
  logic [5:0]           r_al_min;
  logic                 r_alarm_en, r_alarm;
  logic [5:0]           r_alarm_cnt;
  logic                 w_tick, w_inc, w_hit, w_fire;
  logic                 w_snooze_req, w_snz_hit;

  assign w_tick        = (r_presc == c_PRESC_W'(TICK_DIV - 1));
  // Mode beats position beats increment; a lower-priority pulse is dropped.
  assign w_inc         = i_inc_btn & ~i_mode_btn & ~i_pos_btn;
  assign w_hour_inc    = 5'(wrap_inc({1'b0, r_hour}, 6'(HOUR_MAX)));
  assign w_al_hour_inc = 5'(wrap_inc({1'b0, r_al_hour}, 6'(HOUR_MAX)));

  // Mode / position FSM
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_mode <= MODE_CLOCK;
      r_pos  <= POS_SEC;
    end else begin
      r_mode <= w_mode_nxt;
      r_pos  <= w_pos_nxt;
    end
  end

  always_comb begin
    w_mode_nxt = r_mode;
    w_pos_nxt  = r_pos;
    if (i_mode_btn) begin
      case (r_mode)
        MODE_CLOCK: w_mode_nxt = MODE_SETUP;
        MODE_SETUP: w_mode_nxt = MODE_ALARM;
        default:    w_mode_nxt = MODE_CLOCK;
      endcase
      w_pos_nxt = POS_SEC;
    end else if (i_pos_btn && r_mode != MODE_CLOCK) begin
      case (r_pos)
        POS_SEC: w_pos_nxt = POS_MIN;
        POS_MIN: w_pos_nxt = POS_HOUR;
        default: w_pos_nxt = POS_SEC;
      endcase
    end
  end

  // Prescaler: cleared on entry to and throughout SETUP, so no tick can
  // occur while the time is being edited.
  always_ff @(posedge clk) begin
    if (rst_n || w_tick || w_mode_nxt == MODE_SETUP) begin
      r_presc <= '0;
    end else begin
      r_presc <= r_presc + 1'b1;
    end
  end

  // Next time: carry chain on a tick, carry-free field edit in SETUP.
  always_comb begin
    w_sec_nxt  = r_sec;
    w_min_nxt  = r_min;
    w_hour_nxt = r_hour;
    if (w_tick) begin
      w_sec_nxt = wrap_inc(r_sec, 6'd59);
      if (r_sec == 6'd59) begin
        w_min_nxt = wrap_inc(r_min, 6'd59);
        if (r_min == 6'd59) begin
          w_hour_nxt = w_hour_inc;
        end
      end
    end else if (w_inc && r_mode == MODE_SETUP) begin
      case (r_pos)
        POS_SEC:  w_sec_nxt  = wrap_inc(r_sec, 6'd59);
        POS_MIN:  w_min_nxt  = wrap_inc(r_min, 6'd59);
        POS_HOUR: w_hour_nxt = w_hour_inc;
        default:  ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_hour <= '0;
      r_min  <= '0;
      r_sec  <= '0;
    end else begin
      r_hour <= w_hour_nxt;
      r_min  <= w_min_nxt;
      r_sec  <= w_sec_nxt;
    end
  end

  // Alarm time fields; the SEC position has no alarm field to edit.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_al_hour <= '0;
      r_al_min  <= '0;
    end else if (w_inc && r_mode == MODE_ALARM) begin
      case (r_pos)
        POS_MIN:  r_al_min  <= wrap_inc(r_al_min, 6'd59);
        POS_HOUR: r_al_hour <= w_al_hour_inc;
        default:  ;
      endcase
    end
  end

  // Only a tick can produce a match, so SETUP edits never trigger.
  assign w_hit  = w_tick & r_alarm_en & (w_hour_nxt == r_al_hour) &
                  (w_min_nxt == r_al_min) & (w_sec_nxt == 6'd0);
  assign w_fire = w_hit | w_snz_hit;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_alarm_en  <= 1'b0;
      r_alarm     <= 1'b0;
      r_alarm_cnt <= '0;
    end else begin
      if (i_alarm_tgl) begin
        r_alarm_en <= ~r_alarm_en;
      end
      if (i_alarm_tgl || i_mode_btn || w_snooze_req) begin
        r_alarm <= 1'b0;
      end else if (w_fire) begin
        r_alarm     <= 1'b1;
        r_alarm_cnt <= '0;
      end else if (r_alarm && w_tick) begin
        // r_alarm_cnt holds ticks elapsed since assertion, minus one.
        if (r_alarm_cnt == 6'(ALARM_LEN - 1)) begin
          r_alarm <= 1'b0;
        end
        r_alarm_cnt <= r_alarm_cnt + 6'd1;
      end
    end
  end

`ifdef HMS_SNOOZE_EN
  logic [4:0] r_trig_hour, r_snz_hour, w_snz_hour;
  logic [5:0] r_trig_min, r_snz_min, w_snz_min;
  logic [6:0] w_snz_sum;
  logic       r_snz_armed, w_al_edit;

  assign w_al_edit    = w_inc & (r_mode == MODE_ALARM) & (r_pos != POS_SEC);
  assign w_snooze_req = w_inc & (r_mode == MODE_CLOCK) & r_alarm;
  assign w_snz_hit    = w_tick & r_alarm_en & r_snz_armed &
                        (w_hour_nxt == r_snz_hour) & (w_min_nxt == r_snz_min) &
                        (w_sec_nxt == 6'd0);

  // Re-trigger point is relative to the time the alarm last fired.
  always_comb begin
    w_snz_sum  = {1'b0, r_trig_min} + 7'(SNOOZE_MIN);
    w_snz_min  = w_snz_sum[5:0];
    w_snz_hour = r_trig_hour;
    if (w_snz_sum >= 7'd60) begin
      w_snz_min  = 6'(w_snz_sum - 7'd60);
      w_snz_hour = (r_trig_hour >= 5'(HOUR_MAX)) ? 5'd0 : r_trig_hour + 5'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      r_trig_hour <= '0;
      r_trig_min  <= '0;
      r_snz_hour  <= '0;
      r_snz_min   <= '0;
      r_snz_armed <= 1'b0;
    end else begin
      if (w_fire) begin
        r_trig_hour <= w_hour_nxt;
        r_trig_min  <= w_min_nxt;
      end
      if (i_alarm_tgl || w_al_edit) begin
        r_snz_armed <= 1'b0;
      end else if (w_snooze_req) begin
        r_snz_armed <= 1'b1;
        r_snz_hour  <= w_snz_hour;
        r_snz_min   <= w_snz_min;
      end else if (w_snz_hit) begin
        r_snz_armed <= 1'b0;
      end
    end
  end
`else
  assign w_snooze_req = 1'b0;
  assign w_snz_hit    = 1'b0;
`endif

  assign o_hour     = (r_mode == MODE_ALARM) ? r_al_hour : r_hour;
  assign o_min      = (r_mode == MODE_ALARM) ? r_al_min  : r_min;
  assign o_sec      = (r_mode == MODE_ALARM) ? 6'd0      : r_sec;
  assign o_mode     = r_mode;
  assign o_position = r_pos;
  assign o_alarm_en = r_alarm_en;
  assign o_alarm    = r_alarm;
  assign o_tick     = w_tick;

endmodule
`default_nettype wire

// File: doc/hms_alarm_core.md
HMS_ALARM_CORE -- requirements
Module: hms_alarm_core

Interface
REQ-001 Parameter TICK_DIV, default 50000000: clk cycles per one-second tick; legal range 2 or greater.
REQ-002 Parameter HOUR_MAX, default 23: last hour value before wrap to 0; legal values 11 or 23.
REQ-003 Parameter ALARM_LEN, default 30: number of seconds o_alarm stays asserted; legal range 1..63.
REQ-004 Parameter SNOOZE_MIN, default 5: snooze offset in minutes; legal range 1..59.
REQ-005 Port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-006 Port rst_n, input, 1 bit: reset is synchronous and active-high; the name follows the team's port naming, and the polarity is high despite the suffix.
REQ-007 Port i_mode_btn, input, 1 bit: one-cycle pulse, debounced upstream; advances the mode.
REQ-008 Port i_pos_btn, input, 1 bit: one-cycle pulse; advances the edit position.
REQ-009 Port i_inc_btn, input, 1 bit: one-cycle pulse; increments the selected field.
REQ-010 Port i_alarm_tgl, input, 1 bit: one-cycle pulse; toggles o_alarm_en.
REQ-011 Port o_hour, output, 5 bits: displayed hour.
REQ-012 Port o_min, output, 6 bits: displayed minute.
REQ-013 Port o_sec, output, 6 bits: displayed second.
REQ-014 Port o_mode, output, 2 bits: 00 = CLOCK, 01 = SETUP, 10 = ALARM.
REQ-015 Port o_position, output, 2 bits: 00 = SEC, 01 = MIN, 10 = HOUR.
REQ-016 Port o_alarm_en, output, 1 bit: alarm armed.
REQ-017 Port o_alarm, output, 1 bit: alarm sounding, registered.
REQ-018 Port o_tick, output, 1 bit: one-cycle pulse marking each one-second tick.

Function
REQ-019 Prescaler: counts 0..TICK_DIV-1; o_tick is high for the one cycle in which the count equals TICK_DIV-1; the time registers update on that same edge.
REQ-020 Time counters use synchronous clock enables only; no derived or gated clocks are permitted.
REQ-021 Carry chain: sec 59->0 carries into min; min 59->0 carries into hour; hour HOUR_MAX->0.
REQ-022 Mode FSM: on i_mode_btn, CLOCK->SETUP->ALARM->CLOCK; o_position is forced to SEC on every mode change.
REQ-023 Position: in SETUP or ALARM, i_pos_btn cycles SEC->MIN->HOUR->SEC; in CLOCK, i_pos_btn is ignored.
REQ-024 SETUP behaviour:
- Prescaler is held at 0 and the time does not advance.
- i_inc_btn increments the selected time field with wrap and no carry.
- Incrementing the SEC field also clears the prescaler.
REQ-025 ALARM behaviour:
- Time keeps running.
- i_inc_btn increments the selected alarm field (alarm seconds are fixed at 0, so the SEC position increments nothing).
- o_hour/o_min/o_sec show alarm_hour : alarm_min : 00.
REQ-026 CLOCK and SETUP modes display the running time.
REQ-027 Priority: i_mode_btn beats i_pos_btn, which beats i_inc_btn when they arrive in the same cycle; lower-priority pulses in that cycle are dropped.
REQ-028 A tick and an alarm-field increment in the same cycle both take effect.
REQ-029 Alarm trigger:
- Fires only when a tick moves the time to alarm_hour:alarm_min:00 while o_alarm_en=1.
- o_alarm rises on the next edge (1-cycle latency).
- Reaching the match through a SETUP edit never triggers.
REQ-030 Alarm duration: o_alarm falls after ALARM_LEN ticks have elapsed since assertion.
REQ-031 Alarm clearing: o_alarm falls on the edge following any i_alarm_tgl or i_mode_btn.
REQ-032 i_alarm_tgl toggles o_alarm_en; when o_alarm_en goes to 0, any active alarm is cleared on the same edge.

Reset
REQ-033 When rst_n=1 at a clk edge, the following are cleared on that edge:
- time = 00:00:00
- alarm = 00:00
- prescaler = 0
- o_mode = CLOCK
- o_position = SEC
- o_alarm_en = 0
- o_alarm = 0
- o_tick = 0
- snooze state cleared
REQ-034 Reset overrides all pulse inputs; a reset mid-alarm or mid-edit takes effect on that edge with no residual state.

Configuration
REQ-035 With HMS_SNOOZE_EN defined, i_inc_btn in CLOCK mode while o_alarm=1 does the following:
- Clears o_alarm.
- Arms a one-shot re-trigger at (trigger time + SNOOZE_MIN minutes, with hour wrap), seconds = 00.
- The stored alarm_hour/alarm_min are not modified.
- The snooze is cancelled by i_alarm_tgl or by an alarm-field edit.
REQ-036 Without HMS_SNOOZE_EN, i_inc_btn in CLOCK mode is ignored and no snooze logic is synthesised.

Verification
REQ-037 TICK_DIV=4, reset, then 240 clk cycles -> o_tick pulses every 4th cycle; time = 00:01:00 at cycle 240.
REQ-038 Time preset to 23:59:59, then one tick -> 00:00:00; with HOUR_MAX=11, 11:59:59 -> 00:00:00.
REQ-039 Alarm 00:02, armed, time 00:01:59, then tick -> o_alarm=1 one cycle after o_tick and stays high for exactly 30 ticks.
REQ-040 SETUP mode, SEC position, i_mode_btn and i_inc_btn in the same cycle -> mode=ALARM, position=SEC, time unchanged.
REQ-041 Alarm sounding, then i_alarm_tgl -> o_alarm=0 and o_alarm_en=0 on the next edge; assert rst_n mid-alarm -> all outputs at reset values.
REQ-042 HMS_SNOOZE_EN defined, alarm at 00:02 sounding, i_inc_btn in CLOCK mode -> o_alarm=0; o_alarm re-asserts when time reaches 00:07:00.
